alu181_seq: RTL and testbench

ALU181_SEQ -- requirements
Module: alu181_seq

---
 rtl/alu181_seq.sv | 173 +++++++++++++++++
 tb/tb_alu181_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_seq.sv
// alu181_seq: multi-nibble ALU sequencer around an external 4-bit '181-style slice.
// It accepts one W-bit request, walks the slice across each nibble with a chained carry,
// and presents the assembled result on the response port until it is consumed.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. req_ready is high only in IDLE, so at most one
// operation is ever in flight. rsp_valid is high only in DONE, and rsp_y/rsp_co
// hold steady until rsp_ready is sampled high.
module alu181_seq #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    // request
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_s,
    input  logic         req_m,
    input  logic         req_ci,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    // external combinational slice
    output logic [3:0]   alu_s,
    output logic         alu_m,
    output logic         alu_ci,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    input  logic [3:0]   alu_y,
    input  logic         alu_co,
    // response
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_y,
    output logic         rsp_co,
    // debug view of the FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
    output logic [1:0]   dbg_state
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cy_q, cy_d;
    logic [3:0]    s_q, s_d;
    logic          m_q, m_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            s_q     <= '0;
            m_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            s_q     <= s_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic: accept in IDLE, step through nibbles in RUN, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)          state_d = RUN;
            RUN:     if (idx_q == LAST_IDX)  state_d = DONE;
            DONE:    if (rsp_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Select the current operand nibbles from the latched operands.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    // Datapath updates: latch request on accept, collect slice results and carry in RUN.
    always_comb begin
        idx_d = idx_q;
        cy_d  = cy_q;
        s_d   = s_q;
        m_d   = m_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    s_d   = req_s;
                    m_d   = req_m;
                    a_d   = req_a;
                    b_d   = req_b;
                    cy_d  = req_ci;
                    idx_d = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) begin
                        res_d[4*i +: 4] = alu_y;
                    end
                end
                // Logic mode keeps the carry untouched; the slice carry is meaningless there.
                if (!m_q) begin
                    cy_d = alu_co;
                end
                // Last nibble leaves idx parked rather than wrapping.
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: slice drive only in RUN, response only in DONE, zero elsewhere.
    always_comb begin
        req_ready = rst_n && (state_q == IDLE);
        alu_s     = '0;
        alu_m     = 1'b0;
        alu_ci    = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        rsp_valid = 1'b0;
        rsp_y     = '0;
        rsp_co    = 1'b0;
        if (state_q == RUN) begin
            alu_s  = s_q;
            alu_m  = m_q;
            alu_ci = cy_q;
            alu_a  = nib_a;
            alu_b  = nib_b;
        end
        if (state_q == DONE) begin
            rsp_valid = 1'b1;
            rsp_y     = res_q;
            rsp_co    = m_q ? 1'b0 : cy_q;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu181_seq.sv
// tb_alu181_seq: directed bench for alu181_seq with a behavioural 4-bit slice,
// a queue of expected {co, y} results and a final summary.
module tb_alu181_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_s;
  logic         req_m;
  logic         req_ci;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_ci;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_y;
  logic         alu_co;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_co;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  alu181_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_m(req_m), .req_ci(req_ci),
    .req_a(req_a), .req_b(req_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_ci(alu_ci),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_co(alu_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_co(rsp_co),
    .dbg_state(dbg_state)
  );

  // ---------------- external slice model ----------------
  function automatic logic [4:0] slice(input logic [3:0] s, input logic m, input logic ci,
                                       input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    r = '0;
    if (m) begin
      case (s)
        4'b0000: r[3:0] = ~a;
        4'b0001: r[3:0] = ~(a | b);
        4'b0010: r[3:0] = ~a & b;
        4'b0011: r[3:0] = 4'h0;
        4'b0100: r[3:0] = ~(a & b);
        4'b0101: r[3:0] = ~b;
        4'b0110: r[3:0] = a ^ b;
        4'b0111: r[3:0] = a & ~b;
        4'b1000: r[3:0] = ~a | b;
        4'b1001: r[3:0] = ~(a ^ b);
        4'b1010: r[3:0] = b;
        4'b1011: r[3:0] = a & b;
        4'b1100: r[3:0] = 4'hF;
        4'b1101: r[3:0] = a | ~b;
        4'b1110: r[3:0] = a | b;
        default: r[3:0] = a;
      endcase
    end else begin
      case (s)
        4'b1001: r = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        4'b0110: r = {1'b0, a} + {1'b0, ~b} + {4'b0, ci};
        default: r = {1'b0, a} + {4'b0, ci};
      endcase
    end
    return r;
  endfunction

  always_comb {alu_co, alu_y} = slice(alu_s, alu_m, alu_ci, alu_a, alu_b);

  // Whole-word reference for additions.
  function automatic logic [W:0] exp_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one full operation ----------------
  task automatic run_op(input string tag, input logic [3:0] s, input logic m, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] exp,
                        input bit scramble, input bit early_ready, input int hold,
                        input bit ci_en, input logic [NIBBLES-1:0] ci_exp);
    logic [W:0] e;
    logic [NIBBLES-1:0] ci_seq;
    logic [W-1:0] y0;
    logic co0;
    int lat;
    exp_q.push_back(exp);
    @(negedge clk);
    req_s = s; req_m = m; req_ci = ci; req_a = a; req_b = b; req_valid = 1'b1;
    chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (early_ready) rsp_ready = 1'b1;
    chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    ci_seq = '0;
    while (rsp_valid !== 1'b1 && lat < 4 * NIBBLES) begin
      if (lat < NIBBLES) ci_seq[lat] = alu_ci;
      if (scramble) begin
        req_a = W'($urandom);
        req_b = W'($urandom);
        req_s = 4'($urandom);
        req_m = 1'($urandom);
        req_ci = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
    if (ci_en) chk({tag, "_alu_ci_seq"}, 32'(ci_seq), 32'(ci_exp));
    e = exp_q.pop_front();
    chk({tag, "_rsp_y"}, 32'(rsp_y), 32'(e[W-1:0]));
    chk({tag, "_rsp_co"}, 32'(rsp_co), 32'(e[W]));
    chk({tag, "_req_ready_done"}, 32'(req_ready), 32'd0);
    y0 = rsp_y;
    co0 = rsp_co;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_y"}, 32'(rsp_y), 32'(y0));
      chk({tag, "_hold_co"}, 32'(rsp_co), 32'(co0));
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_post_y"}, 32'(rsp_y), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rci;
    int stale;
    req_valid = 1'b0; req_s = '0; req_m = 1'b0; req_ci = 1'b0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset state.
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_alu_out", 32'({alu_s, alu_m, alu_ci, alu_a, alu_b}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_state", 32'(dbg_state), 32'd0);

    // Add without carry-out.
    run_op("add", 4'b1001, 1'b0, 1'b0, 16'h1234, 16'h1111, 17'h02345, 0, 0, 0, 1, 4'b0000);
    // Full carry ripple.
    run_op("ripple", 4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 17'h10000, 0, 0, 0, 1, 4'b1110);
    // Logic AND: carry passes through untouched, rsp_co forced 0.
    run_op("and", 4'b1011, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 17'h0F000, 0, 0, 0, 1, 4'b1111);
    // Backpressure for five cycles in DONE.
    run_op("bp", 4'b1001, 1'b0, 1'b1, 16'h0F0F, 16'h0101, 17'h01011, 0, 0, 5, 0, '0);
    // Request inputs change every RUN cycle.
    run_op("iso", 4'b1001, 1'b0, 1'b1, 16'h8000, 16'h8000, 17'h10001, 1, 0, 0, 0, '0);
    // Subtract with rsp_ready already high during RUN.
    run_op("sub", 4'b0110, 1'b0, 1'b1, 16'h5000, 16'h1234, 17'h13DCC, 0, 1, 0, 0, '0);
    // Logic XOR.
    run_op("xor", 4'b0110, 1'b1, 1'b0, 16'hA5A5, 16'h0FF0, 17'h0AA55, 0, 0, 0, 0, '0);
    // Random additions.
    for (int k = 0; k < 4; k++) begin
      ra = W'($urandom_range(0, 32'hFFFF));
      rb = W'($urandom_range(0, 32'hFFFF));
      rci = 1'($urandom_range(0, 1));
      run_op("rand_add", 4'b1001, 1'b0, rci, ra, rb, exp_add(ra, rb, rci), 0, 0,
             int'($urandom_range(0, 2)), 0, '0);
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    req_s = 4'b1001; req_m = 1'b0; req_ci = 1'b1; req_a = 16'hABCD; req_b = 16'h1234;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_alu_a_idx2", 32'(alu_a), 32'hB);
    chk("mid_alu_b_idx2", 32'(alu_b), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_out", 32'({alu_s, alu_m, alu_ci, alu_a, alu_b}), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_co, rsp_y}), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) stale++;
    end
    chk("mid_no_stale_rsp", 32'(stale), 32'd0);

    // Normal operation resumes after the abort.
    run_op("after_rst", 4'b1001, 1'b0, 1'b0, 16'h0001, 16'h0002, 17'h00003, 0, 0, 0, 0, '0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
